// File: rtl/aes_pkg.sv
// Shared AES-128 tables, GF(2^8) helpers and the decrypt FSM state type.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } fsm_state_e;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Rcon for key-schedule steps 1..10, step 1 in the top byte.
  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = {~x, 3'b000};
    return SBOX[pos +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = {~x, 3'b000};
    return INV_SBOX[pos +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] step);
    logic [6:0] pos;
    if (step == 4'd0 || step > 4'd10) begin
      return 8'h00;
    end
    pos = {4'd10 - step, 3'b000};
    return RCON[pos +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse AES round; 'last' skips InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted, subbed, keyed, mixed;

  // InvShiftRows: row r rotates right by r; byte index is r + 4*c.
  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[127 - 8*(r + 4*c) -: 8] = state_in[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
  end

  // InvSubBytes followed by AddRoundKey.
  always_comb begin
    subbed = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      subbed[127 - 8*b -: 8] = inv_sbox(shifted[127 - 8*b -: 8]);
    end
    keyed = subbed ^ round_key;
  end

  // InvMixColumns per column, then pick mixed or unmixed output.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = keyed[127 - 32*c -: 8];
      a1 = keyed[119 - 32*c -: 8];
      a2 = keyed[111 - 32*c -: 8];
      a3 = keyed[103 - 32*c -: 8];
      mixed[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mixed[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mixed[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mixed[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    state_out = last ? keyed : mixed;
  end

endmodule

// File: rtl/key_expansion.sv
// One forward AES-128 key-schedule step: round key i-1 -> round key i.
module key_expansion
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon_in,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, rot, temp;

  // RotWord/SubWord/Rcon on the last word, then the xor chain across words.
  always_comb begin
    w0   = prev_key[127:96];
    w1   = prev_key[95:64];
    w2   = prev_key[63:32];
    w3   = prev_key[31:0];
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]) ^ rcon_in, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    next_key[127:96] = w0 ^ temp;
    next_key[95:64]  = w1 ^ w0 ^ temp;
    next_key[63:32]  = w2 ^ w1 ^ w0 ^ temp;
    next_key[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;
  end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: expands the key forward, then runs rounds in reverse.
module aes_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  fsm_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] aes_state_q, aes_state_d;
  logic [127:0] pt_q, pt_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         busy_q, busy_d;

  logic [127:0] rk_q [0:10];
  logic         rk_we;
  logic [3:0]   rk_widx;
  logic [127:0] rk_wdata;

  logic [3:0]   rd_idx, prev_idx;
  logic [127:0] kexp_out, round_out;

  // Round-key read ports: current counter and its predecessor, clamped in range.
  always_comb begin
    rd_idx   = (cnt_q > 4'd10) ? 4'd0 : cnt_q;
    prev_idx = (cnt_q == 4'd0 || cnt_q > 4'd10) ? 4'd0 : cnt_q - 4'd1;
  end

  key_expansion u_kexp (
    .prev_key (rk_q[prev_idx]),
    .rcon_in  (rcon(cnt_q)),
    .next_key (kexp_out)
  );

  // Counter reaches 0 on the last ROUND, so FINAL reads rk0 through the same port.
  aes_inv_round u_round (
    .state_in  (aes_state_q),
    .round_key (rk_q[rd_idx]),
    .last      (state_q == ST_FINAL),
    .state_out (round_out)
  );

  // Next-state, datapath and key-file write control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aes_state_d = aes_state_q;
    pt_d        = pt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    rk_we       = 1'b0;
    rk_widx     = 4'd0;
    rk_wdata    = key;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          aes_state_d = data_in;
          rk_we       = 1'b1;
          rk_widx     = 4'd0;
          rk_wdata    = key;
          cnt_d       = 4'd1;
          state_d     = ST_KEYEXP;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_KEYEXP: begin
        rk_we    = 1'b1;
        rk_widx  = rd_idx;
        rk_wdata = kexp_out;
        if (cnt_q >= 4'd10) begin
          state_d = ST_INIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_INIT: begin
        aes_state_d = aes_state_q ^ rk_q[rd_idx];
        cnt_d       = 4'd9;
        state_d     = ST_ROUND;
      end
      ST_ROUND: begin
        aes_state_d = round_out;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        pt_d        = round_out;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 4'd0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // FSM and datapath registers with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      aes_state_q <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aes_state_q <= aes_state_d;
      pt_q        <= pt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Round-key file, written once per job and never reset.
  always_ff @(posedge clk) begin
    if (rk_we) rk_q[rk_widx] <= rk_wdata;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign plaintext = pt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using FIPS-197 vectors.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n;
  logic [127:0] held;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plaintext (plaintext),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] ct, input logic [127:0] k);
    @(negedge clk);
    data_in  = ct;
    key      = k;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_in_ready", in_ready, 1'b0);
  endtask

  task automatic wait_out(input bit toggle, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
      if (toggle && !out_valid) begin
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", out_valid, 1'b0);
    chk("hs_in_ready", in_ready, 1'b1);
    chk("hs_busy", busy, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    key       = '0;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_plaintext", plaintext, 128'h0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_out_valid", out_valid, 1'b0);

    // out_ready while idle does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle_ready_in_ready", in_ready, 1'b1);
    chk("idle_ready_out_valid", out_valid, 1'b0);
    chk("idle_ready_busy", busy, 1'b0);

    // C.1 with input toggling while in flight
    accept(C1_CT, C1_KEY);
    wait_out(1'b1, n);
    chk("c1_latency", 128'(n), 128'd21);
    chk("c1_plaintext", plaintext, C1_PT);
    chk("c1_busy_done", busy, 1'b1);
    handshake();

    // App. B with 15 cycles of backpressure and in_valid held high
    accept(B_CT, B_KEY);
    wait_out(1'b0, n);
    chk("b_latency", 128'(n), 128'd21);
    chk("b_plaintext", plaintext, B_PT);
    held     = plaintext;
    data_in  = C1_CT;
    key      = C1_KEY;
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("bp_plaintext", plaintext, held);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    handshake();
    chk("bp_after_plaintext", plaintext, B_PT);

    // Reset at cycle 12 of a job
    accept(C1_CT, C1_KEY);
    repeat (11) tick();
    reset = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_plaintext", plaintext, 128'h0);
    chk("abort_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    accept(C1_CT, C1_KEY);
    wait_out(1'b0, n);
    chk("post_abort_latency", 128'(n), 128'd21);
    chk("post_abort_plaintext", plaintext, C1_PT);
    handshake();

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    @(negedge clk);
    data_in  = C1_CT;
    key      = C1_KEY;
    in_valid = 1'b1;
    tick();
    chk("b2b_accept1", in_ready, 1'b0);
    data_in = B_CT;
    key     = B_KEY;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("b2b_latency1", 128'(n), 128'd21);
    chk("b2b_plaintext1", plaintext, C1_PT);
    tick();
    chk("b2b_idle_in_ready", in_ready, 1'b1);
    chk("b2b_idle_out_valid", out_valid, 1'b0);
    tick();
    chk("b2b_accept2_in_ready", in_ready, 1'b0);
    chk("b2b_accept2_busy", busy, 1'b1);
    in_valid = 1'b0;
    wait_out(1'b0, n);
    chk("b2b_latency2", 128'(n), 128'd21);
    chk("b2b_plaintext2", plaintext, B_PT);
    tick();
    chk("b2b_final_out_valid", out_valid, 1'b0);
    chk("b2b_final_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_decrypt_iter.md
AES_DECRYPT_ITER -- requirements
Module: aes_decrypt_iter

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  ciphertext and key on data_in/key are valid.
REQ-006 in_ready  output  1  block can accept a new job.
REQ-007 data_in  input  128  AES-128 ciphertext, byte 0 in bits [127:120].
REQ-008 key  input  128  AES-128 cipher key, byte 0 in bits [127:120].
REQ-009 out_valid  output  1  plaintext is valid.
REQ-010 out_ready  input  1  consumer accepts plaintext.
REQ-011 plaintext  output  128  decrypted block, same byte order as data_in.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, KEYEXP, INIT, ROUND, FINAL and DONE.
REQ-014 in_ready SHALL be high only in IDLE; a job is accepted on the rising edge where in_valid and in_ready are both high.
REQ-015 On accept, the block SHALL capture data_in, store key as rk0, clear a 4-bit round counter to 1, and move to KEYEXP.
REQ-016 KEYEXP SHALL compute one forward round key per cycle (rk1..rk10, Rcon 01,02,04,08,10,20,40,80,1b,36), store each in an 11x128 key register file, and leave after rk10 is stored (10 cycles).
REQ-017 INIT SHALL take 1 cycle and set state to ciphertext XOR rk10.
REQ-018 ROUND SHALL take 9 cycles, for i = 9 down to 1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR rk_i).
REQ-019 FINAL SHALL take 1 cycle: plaintext <= InvSubBytes(InvShiftRows(state)) XOR rk0, out_valid <= 1, next state DONE.
REQ-020 Latency SHALL be exactly 21 cycles from the accept edge to the edge that raises out_valid.
REQ-021 In DONE, out_valid and plaintext SHALL hold stable until an edge where out_ready is high; on that edge out_valid <= 0 and the FSM returns to IDLE.
REQ-022 out_ready high while out_valid is low SHALL have no effect; in_valid outside IDLE SHALL be ignored, and data_in/key need not be held after accept.
REQ-023 After returning to IDLE, the earliest new accept SHALL be one cycle after the handshake edge, so back-to-back throughput is one block per 23 cycles.
REQ-024 The round counter SHALL never exceed 10; any unused state encoding SHALL return to IDLE on the next edge.

Reset
REQ-025 Reset low SHALL force: FSM to IDLE, in_ready = 1 after deassertion, out_valid = 0, plaintext = 0, busy = 0, counter = 0, and state register = 0.
REQ-026 Reset asserted mid-job SHALL abort the job with no output; the key register file does not need reset.

Structure
REQ-027 A shared package aes_pkg SHALL hold the inverse S-box and forward S-box tables, the Rcon table, GF(2^8) xtime/multiply functions, and the FSM state typedef.
REQ-028 One combinational sub-module aes_inv_round SHALL implement InvShiftRows, InvSubBytes, AddRoundKey and optional InvMixColumns, selected by a "last" input.
REQ-029 The forward key-schedule step SHALL reuse the existing key_expansion block.

Verification
REQ-030 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid exactly 21 cycles after accept.
REQ-031 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, data_in 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
REQ-032 Backpressure: hold out_ready low for 15 cycles after out_valid -> plaintext is stable, in_ready stays 0, and no new accept occurs; out_ready pulse -> IDLE next cycle.
REQ-033 Reset at cycle 12 of a job -> out_valid 0, plaintext 0 immediately; a following C.1 job completes correctly.
REQ-034 Back-to-back C.1 then App. B with in_valid held high -> the second accept occurs one cycle after the first output handshake, and both results are correct.
REQ-035 Toggle in_valid and data_in during KEYEXP/ROUND -> no effect on the result of the in-flight job.
